// File: rtl/address_pkg.sv
// Shared definitions for the SNES address mapper.
//   mode_e     : cartridge mapping modes, encoded as the MAPPER_SEL values.
//   state_e    : mode-change handshake FSM states.
//   SramWindow : start of the HiROM-style SaveRAM window within a bank.
package address_pkg;

   typedef enum logic [1:0] {
      ModeHirom   = 2'd0,
      ModeLorom   = 2'd1,
      ModeExhirom = 2'd2,
      ModeMenu    = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StWaitBus = 2'd1,
      StApply   = 2'd2,
      StAck     = 2'd3
   } state_e;

   localparam logic [14:0] SramWindow = 15'h6000;

endpackage

// File: rtl/addr_decode.sv
// Combinational per-mode address decode.
//   addr        : synchronised SNES address (at least 24 bits wide)
//   mode        : active mapping mode
//   rom_mask    : ROM size mask applied to the ROM offset
//   sram_mask   : SaveRAM size mask applied to the SaveRAM offset
//   mapped_addr : base + masked offset, SaveRAM path when is_saveram, ROM path otherwise
//   is_rom      : address falls in ROM space
//   is_saveram  : address falls in SaveRAM space (never together with is_rom)
module addr_decode
   import address_pkg::*;
#(
   parameter int unsigned         ADDR_W    = 24,
   parameter logic [ADDR_W-1:0]   ROM_BASE  = 24'h000000,
   parameter logic [ADDR_W-1:0]   SRAM_BASE = 24'hE00000,
   parameter logic [ADDR_W-1:0]   MENU_BASE = 24'hC00000
) (
   input  logic [ADDR_W-1:0] addr,
   input  mode_e             mode,
   input  logic [ADDR_W-1:0] rom_mask,
   input  logic [ADDR_W-1:0] sram_mask,
   output logic [ADDR_W-1:0] mapped_addr,
   output logic              is_rom,
   output logic              is_saveram
);

   logic [ADDR_W-1:0] hi_off;
   logic [ADDR_W-1:0] lo_off;
   logic [ADDR_W-1:0] ex_off;
   logic [ADDR_W-1:0] hi_sram_off;
   logic [ADDR_W-1:0] lo_sram_off;
   logic [14:0]       sram_win;
   logic              hi_rom;
   logic              hi_sram;
   logic              lo_sram;

   always_comb begin
      // HiROM-style flags; A22|A15 excludes the SaveRAM term so the flags never overlap.
      hi_rom  = addr[22] | addr[15];
      hi_sram = ~addr[22] & addr[21] & addr[20] & addr[14] & addr[13] & ~addr[15];
      lo_sram = (addr[22:20] == 3'b111) & ~addr[15];

      hi_off         = '0;
      hi_off[22:0]   = addr[22:0];
      lo_off         = '0;
      lo_off[21:0]   = {addr[22:16], addr[14:0]};
      ex_off         = '0;
      ex_off[22:0]   = {~addr[23], addr[21:0]};

      // Wraps modulo 2^15 so the window start maps to offset zero.
      sram_win          = addr[14:0] - SramWindow;
      hi_sram_off       = '0;
      hi_sram_off[14:0] = sram_win;
      lo_sram_off       = '0;
      lo_sram_off[18:0] = {addr[19:16], addr[14:0]};

      is_rom      = hi_rom;
      is_saveram  = hi_sram;
      mapped_addr = ROM_BASE + (hi_off & rom_mask);

      case (mode)
         ModeLorom: begin
            is_saveram  = lo_sram;
            is_rom      = addr[15] & ~lo_sram;
            mapped_addr = lo_sram ? SRAM_BASE + (lo_sram_off & sram_mask)
                                  : ROM_BASE + (lo_off & rom_mask);
         end
         ModeExhirom: begin
            mapped_addr = hi_sram ? SRAM_BASE + (hi_sram_off & sram_mask)
                                  : ROM_BASE + (ex_off & rom_mask);
         end
         ModeMenu: begin
            mapped_addr = hi_sram ? SRAM_BASE + (hi_sram_off & sram_mask)
                                  : MENU_BASE + (hi_off & rom_mask);
         end
         default: begin
            mapped_addr = hi_sram ? SRAM_BASE + (hi_sram_off & sram_mask)
                                  : ROM_BASE + (hi_off & rom_mask);
         end
      endcase
   end

endmodule

// File: rtl/address_mapper.sv
// SNES cartridge address mapper.
//   CLK, RST_N     : system clock, asynchronous active-low reset
//   SNES_ADDR      : raw SNES address bus (asynchronous)
//   SNES_CS        : cart select, active low (asynchronous)
//   MAPPER_SEL     : requested mode (0 HiROM, 1 LoROM, 2 ExHiROM, 3 menu)
//   MAPPER_REQ/ACK : four-phase handshake adopting MAPPER_SEL
//   SAVERAM_MASK   : SaveRAM size mask (quasi-static)
//   ROM_MASK       : ROM size mask (quasi-static)
//   ROM_ADDR       : registered mapped address
//   IS_ROM         : registered ROM region flag
//   IS_SAVERAM     : registered SaveRAM region flag
//   ADDR_VALID     : one-cycle pulse when outputs reflect a newly stable address
module address_mapper
   import address_pkg::*;
#(
   parameter int unsigned         ADDR_W        = 24,
   parameter int unsigned         STABLE_CYCLES = 2,
   parameter logic [ADDR_W-1:0]   ROM_BASE      = 24'h000000,
   parameter logic [ADDR_W-1:0]   SRAM_BASE     = 24'hE00000,
   parameter logic [ADDR_W-1:0]   MENU_BASE     = 24'hC00000
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [ADDR_W-1:0] SNES_ADDR,
   input  logic              SNES_CS,
   input  logic [1:0]        MAPPER_SEL,
   input  logic              MAPPER_REQ,
   output logic              MAPPER_ACK,
   input  logic [ADDR_W-1:0] SAVERAM_MASK,
   input  logic [ADDR_W-1:0] ROM_MASK,
   output logic [ADDR_W-1:0] ROM_ADDR,
   output logic              IS_ROM,
   output logic              IS_SAVERAM,
   output logic              ADDR_VALID
);

   localparam int unsigned     CntW   = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

   logic [ADDR_W-1:0] addr_s1_q, addr_s2_q, addr_prev_q;
   logic              cs_s1_q, cs_s2_q;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              fire;
   mode_e             mode_q, mode_d;
   mode_e             sel_q, sel_d;
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] rom_addr_q;
   logic              is_rom_q, is_sram_q, valid_q;

   logic [ADDR_W-1:0] dec_addr;
   logic              dec_rom, dec_sram;

   addr_decode #(
      .ADDR_W    (ADDR_W),
      .ROM_BASE  (ROM_BASE),
      .SRAM_BASE (SRAM_BASE),
      .MENU_BASE (MENU_BASE)
   ) u_addr_decode (
      .addr        (addr_s2_q),
      .mode        (mode_q),
      .rom_mask    (ROM_MASK),
      .sram_mask   (SAVERAM_MASK),
      .mapped_addr (dec_addr),
      .is_rom      (dec_rom),
      .is_saveram  (dec_sram)
   );

   // Stability counter; a mode change restarts it so the held address is decoded again.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == StApply) begin
         cnt_d = '0;
      end else if (addr_s2_q != addr_prev_q) begin
         cnt_d = '0;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + CntW'(1);
      end
      fire = (cnt_d == CntMax) && (cnt_q != CntMax);
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      mode_d  = mode_q;
      unique case (state_q)
         StIdle: begin
            if (MAPPER_REQ) begin
               state_d = StWaitBus;
               sel_d   = mode_e'(MAPPER_SEL);
            end
         end
         StWaitBus: begin
            // Only switch while the cart is deselected so no access sees a mixed mapping.
            if (cs_s2_q) begin
               state_d = StApply;
            end
         end
         StApply: begin
            state_d = StAck;
            mode_d  = sel_q;
         end
         StAck: begin
            if (!MAPPER_REQ) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         addr_s1_q   <= '0;
         addr_s2_q   <= '0;
         addr_prev_q <= '0;
         cs_s1_q     <= 1'b0;
         cs_s2_q     <= 1'b0;
         cnt_q       <= '0;
         mode_q      <= ModeHirom;
         sel_q       <= ModeHirom;
         state_q     <= StIdle;
         rom_addr_q  <= '0;
         is_rom_q    <= 1'b0;
         is_sram_q   <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         addr_s1_q   <= SNES_ADDR;
         addr_s2_q   <= addr_s1_q;
         addr_prev_q <= addr_s2_q;
         cs_s1_q     <= SNES_CS;
         cs_s2_q     <= cs_s1_q;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         sel_q       <= sel_d;
         state_q     <= state_d;
         valid_q     <= fire;
         if (fire) begin
            rom_addr_q <= dec_addr;
            is_rom_q   <= dec_rom;
            is_sram_q  <= dec_sram;
         end
      end
   end

   assign MAPPER_ACK = (state_q == StAck);
   assign ROM_ADDR   = rom_addr_q;
   assign IS_ROM     = is_rom_q;
   assign IS_SAVERAM = is_sram_q;
   assign ADDR_VALID = valid_q;

endmodule

// File: tb/tb_address_mapper.sv
module tb_address_mapper;

   localparam int S = 2;

   typedef struct packed {
      logic [23:0] addr;
      logic        rom;
      logic        sram;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] snes_addr;
   logic        snes_cs;
   logic [1:0]  mapper_sel;
   logic        mapper_req;
   logic        mapper_ack;
   logic [23:0] sram_mask;
   logic [23:0] rom_mask;
   logic [23:0] rom_addr;
   logic        is_rom;
   logic        is_sram;
   logic        addr_valid;

   exp_t        q[$];
   int          total = 0;
   int          bad = 0;
   int          pulses = 0;
   int          model_mode = 0;
   logic [23:0] cur_addr = '0;
   bit          last_pushed = 1'b1;

   always #5 clk = ~clk;

   address_mapper #(
      .ADDR_W        (24),
      .STABLE_CYCLES (S),
      .ROM_BASE      (24'h000000),
      .SRAM_BASE     (24'hE00000),
      .MENU_BASE     (24'hC00000)
   ) dut (
      .CLK          (clk),
      .RST_N        (rst_n),
      .SNES_ADDR    (snes_addr),
      .SNES_CS      (snes_cs),
      .MAPPER_SEL   (mapper_sel),
      .MAPPER_REQ   (mapper_req),
      .MAPPER_ACK   (mapper_ack),
      .SAVERAM_MASK (sram_mask),
      .ROM_MASK     (rom_mask),
      .ROM_ADDR     (rom_addr),
      .IS_ROM       (is_rom),
      .IS_SAVERAM   (is_sram),
      .ADDR_VALID   (addr_valid)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   function automatic bit bt(input int unsigned v, input int n);
      return ((v >> n) & 1) != 0;
   endfunction

   // Reference mapping straight from the mode rules, using integer arithmetic.
   function automatic exp_t model(input logic [23:0] a, input int mode,
                                  input logic [23:0] rm, input logic [23:0] sm);
      exp_t        e;
      int unsigned av, rom_off, sram_off, base;
      av = a;
      if (mode == 1) begin
         e.sram   = (((av >> 20) & 7) == 7) && !bt(av, 15);
         e.rom    = bt(av, 15) && !e.sram;
         rom_off  = ((av >> 16) & 'h7F) * 'h8000 + av % 'h8000;
         sram_off = ((av >> 16) & 'hF) * 'h8000 + av % 'h8000;
      end else begin
         e.rom  = bt(av, 22) || bt(av, 15);
         e.sram = !bt(av, 22) && bt(av, 21) && bt(av, 20) && bt(av, 14) && bt(av, 13)
                  && !bt(av, 15);
         if (mode == 2) rom_off = (bt(av, 23) ? 0 : 'h400000) + av % 'h400000;
         else           rom_off = av % 'h800000;
         sram_off = (av % 'h8000 + 'h8000 - 'h6000) % 'h8000;
      end
      base = (mode == 3) ? 'hC00000 : 0;
      if (e.sram) e.addr = 24'(('hE00000 + (sram_off & sm)) % 'h1000000);
      else        e.addr = 24'((base + (rom_off & rm)) % 'h1000000);
      return e;
   endfunction

   // Monitor: every ADDR_VALID pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && addr_valid === 1'b1) begin
         pulses++;
         check("flags_exclusive", {31'd0, is_rom & is_sram}, 32'd0);
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got addr=%h rom=%b sram=%b required no pulse",
                     rom_addr, is_rom, is_sram);
         end else begin
            e = q.pop_front();
            check("pulse_addr", {8'd0, rom_addr}, {8'd0, e.addr});
            check("pulse_rom", {31'd0, is_rom}, {31'd0, e.rom});
            check("pulse_sram", {31'd0, is_sram}, {31'd0, e.sram});
         end
      end
   end

   task automatic hold(input logic [23:0] a, input int h);
      snes_addr   = a;
      cur_addr    = a;
      last_pushed = (h >= S + 1);
      if (last_pushed) q.push_back(model(a, model_mode, rom_mask, sram_mask));
      repeat (h) @(negedge clk);
   endtask

   // Keep the current address; a segment that was too short becomes stable here.
   task automatic settle(input int n);
      if (!last_pushed) begin
         q.push_back(model(cur_addr, model_mode, rom_mask, sram_mask));
         last_pushed = 1'b1;
      end
      repeat (n) @(negedge clk);
   endtask

   task automatic handshake(input int m, input int cs_low);
      int early;
      int k;
      settle(S + 4);
      snes_cs = 1'b0;
      repeat (3) @(negedge clk);
      mapper_sel = 2'(m);
      mapper_req = 1'b1;
      early = 0;
      repeat (cs_low) begin
         @(negedge clk);
         if (mapper_ack) early++;
      end
      check("ack_withheld", early, 0);
      mapper_sel = 2'(m + 1);
      model_mode = m;
      q.push_back(model(cur_addr, model_mode, rom_mask, sram_mask));
      snes_cs = 1'b1;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (mapper_ack) break;
      end
      check("ack_seen", {31'd0, mapper_ack}, 32'd1);
      mapper_req = 1'b0;
      @(negedge clk);
      check("ack_drop", {31'd0, mapper_ack}, 32'd0);
      settle(6);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q.delete();
      snes_addr  = '0;
      cur_addr   = '0;
      mapper_req = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rom_addr", {8'd0, rom_addr}, 32'd0);
      check("rst_valid", {31'd0, addr_valid}, 32'd0);
      rst_n      = 1'b1;
      model_mode = 0;
      // Address 0 sits in the reset synchronisers and counts as a stable address.
      q.push_back(model(24'h0, 0, rom_mask, sram_mask));
      last_pushed = 1'b1;
   endtask

   initial begin
      int          k, p0, p1, acks;
      logic [23:0] a;
      snes_cs    = 1'b1;
      mapper_sel = 2'd0;
      mapper_req = 1'b0;
      rom_mask   = 24'hFFFFFF;
      sram_mask  = 24'hFFFFFF;
      snes_addr  = '0;
      rst_n      = 1'b0;
      @(negedge clk);
      do_reset();
      settle(6);

      // HiROM SaveRAM window, latency and single pulse.
      snes_addr   = 24'h306000;
      cur_addr    = 24'h306000;
      last_pushed = 1'b1;
      q.push_back(model(24'h306000, 0, rom_mask, sram_mask));
      for (k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (addr_valid) break;
      end
      check("latency", k, 5);
      check("hirom_sram_flag", {31'd0, is_sram}, 32'd1);
      check("hirom_sram_addr", {8'd0, rom_addr}, 32'h00E00000);
      p0 = pulses;
      settle(10);
      check("single_pulse", pulses - p0, 1);

      // Toggling address never stabilises; a following hold pulses once.
      settle(4);
      p0 = pulses;
      for (int i = 0; i < 20; i++) hold((i % 2 == 0) ? 24'h123456 : 24'h654321, 1);
      check("toggle_no_pulse", pulses - p0, 0);
      hold(24'h0ABCDE, 10);
      check("toggle_then_hold", pulses - p0, 1);

      // LoROM.
      handshake(1, 2);
      hold(24'h808000, 8);
      check("lorom_rom_flag", {31'd0, is_rom}, 32'd1);
      check("lorom_rom_addr", {8'd0, rom_addr}, 32'd0);
      hold(24'h700010, 8);
      check("lorom_sram_flag", {31'd0, is_sram}, 32'd1);
      check("lorom_sram_addr", {8'd0, rom_addr}, 32'h00E00010);

      // Menu switch while the bus is busy.
      rom_mask = 24'h3FFFFF;
      hold(24'hC00000, 8);
      handshake(3, 10);
      check("menu_rom_addr", {8'd0, rom_addr}, 32'h00C00000);
      check("menu_rom_flag", {31'd0, is_rom}, 32'd1);

      // Randomised segments with occasional mode and mask changes.
      for (int seg = 0; seg < 160; seg++) begin
         if (seg % 20 == 19) begin
            settle(S + 4);
            rom_mask  = 24'($urandom);
            sram_mask = 24'($urandom);
            handshake($urandom_range(0, 3), $urandom_range(1, 3));
         end
         do begin
            a = 24'($urandom);
            case ($urandom_range(0, 3))
               0: a = (a & ~24'h408000) | 24'h306000;
               1: a = (a & ~24'h008000) | 24'h700000;
               default: ;
            endcase
         end while (a == cur_addr);
         hold(a, $urandom_range(1, 5));
      end

      // Reset during WAIT_BUS.
      settle(S + 4);
      rom_mask  = 24'hFFFFFF;
      sram_mask = 24'hFFFFFF;
      handshake(0, 1);
      hold(24'h401234, 8);
      snes_cs = 1'b0;
      settle(3);
      mapper_sel = 2'd2;
      mapper_req = 1'b1;
      settle(2);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_rom_addr", {8'd0, rom_addr}, 32'd0);
      check("async_rst_is_rom", {31'd0, is_rom}, 32'd0);
      check("async_rst_is_sram", {31'd0, is_sram}, 32'd0);
      check("async_rst_valid", {31'd0, addr_valid}, 32'd0);
      check("async_rst_ack", {31'd0, mapper_ack}, 32'd0);
      @(negedge clk);
      do_reset();
      snes_cs = 1'b1;
      acks = 0;
      repeat (12) begin
         @(negedge clk);
         if (mapper_ack) acks++;
      end
      check("no_ack_after_rst", acks, 0);
      hold(24'hC01234, 8);
      check("mode_hirom_after_rst", {8'd0, rom_addr}, 32'h00401234);

      settle(8);
      check("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
